sdram_burst_ctrl: RTL and testbench

Command and sequencing stage of the SDRAM controller. It arbitrates system write, read and periodic refresh requests and drives SDRAM commands and addresses with fixed burst-8, auto-precharge timing. It also generates the `work_state`/`cnt_clk` pair consumed by the downstream SDRAM data read/write stage, which drives and captures the data bus. It operates only after the power-up init sequencer asserts `init_done`.

---
 rtl/sdram_burst_ctrl.sv | 173 +++++++++++++++++
 tb/tb_sdram_burst_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_burst_ctrl.sv
// sdram_burst_ctrl: command sequencer for burst-8, auto-precharge SDRAM access.
// Arbitrates refresh, write and read requests, issues ACT/READ/WRITE/REFRESH
// commands, and publishes work_state/cnt_clk for the data read/write stage.
module sdram_burst_ctrl #(
    parameter int TRCD_CLK   = 2,
    parameter int CL_CLK     = 3,
    parameter int TWR_CLK    = 2,
    parameter int TRP_CLK    = 2,
    parameter int TRFC_CLK   = 7,
    parameter int REF_PERIOD = 780
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init_done,
    input  logic        sys_wr_req,
    input  logic        sys_rd_req,
    input  logic [21:0] sys_addr,
    output logic        sys_wr_ack,
    output logic        sys_rd_ack,
    output logic        sdram_busy,
    output logic [3:0]  sdram_cmd,
    output logic [1:0]  sdram_ba,
    output logic [11:0] sdram_addr,
    output logic [3:0]  work_state,
    output logic [9:0]  cnt_clk
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        ACTIVE = 4'd1,
        TRCD   = 4'd2,
        READ   = 4'd3,
        CL     = 4'd4,
        RD     = 4'd5,
        RWAIT  = 4'd6,
        WRITE  = 4'd7,
        WD     = 4'd8,
        TDAL   = 4'd9,
        AR     = 4'd10,
        TRFC   = 4'd11
    } state_t;

    localparam logic [3:0] CMD_NOP     = 4'b0111;
    localparam logic [3:0] CMD_ACT     = 4'b0011;
    localparam logic [3:0] CMD_READ    = 4'b0101;
    localparam logic [3:0] CMD_WRITE   = 4'b0100;
    localparam logic [3:0] CMD_REFRESH = 4'b0001;

    // Last cnt_clk value of each multi-cycle state (duration minus one)
    localparam logic [9:0] LAST_TRCD  = 10'(TRCD_CLK - 2);
    localparam logic [9:0] LAST_CL    = 10'(CL_CLK - 2);
    localparam logic [9:0] LAST_WD    = 10'd6;
    localparam logic [9:0] LAST_TDAL  = 10'(TWR_CLK + TRP_CLK - 1);
    localparam logic [9:0] LAST_RD    = 10'd7;
    localparam logic [9:0] LAST_RWAIT = 10'(TRP_CLK - 1);
    localparam logic [9:0] LAST_TRFC  = 10'(TRFC_CLK - 2);
    localparam logic [9:0] CNT_MAX    = 10'd1023;

    localparam int             RW       = $clog2(REF_PERIOD);
    localparam logic [RW-1:0]  REF_LAST = RW'(REF_PERIOD - 1);

    state_t          state;
    state_t          next_state;
    logic            is_write;
    logic [21:0]     addr_q;
    logic [RW-1:0]   ref_cnt;
    logic            ref_pending;

    assign work_state = state;

    // Next-state decode: IDLE arbitration plus fixed per-state durations
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (init_done) begin
                    if (ref_pending)
                        next_state = AR;
                    else if (sys_wr_req || sys_rd_req)
                        next_state = ACTIVE;
                end
            end
            ACTIVE: next_state = TRCD;
            TRCD:   if (cnt_clk == LAST_TRCD)  next_state = is_write ? WRITE : READ;
            WRITE:  next_state = WD;
            WD:     if (cnt_clk == LAST_WD)    next_state = TDAL;
            TDAL:   if (cnt_clk == LAST_TDAL)  next_state = IDLE;
            READ:   next_state = CL;
            CL:     if (cnt_clk == LAST_CL)    next_state = RD;
            RD:     if (cnt_clk == LAST_RD)    next_state = RWAIT;
            RWAIT:  if (cnt_clk == LAST_RWAIT) next_state = IDLE;
            AR:     next_state = TRFC;
            TRFC:   if (cnt_clk == LAST_TRFC)  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // FSM state, cycle counter, registered commands/addresses and handshakes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt_clk    <= '0;
            sdram_cmd  <= CMD_NOP;
            sdram_ba   <= '0;
            sdram_addr <= '0;
            sys_wr_ack <= 1'b0;
            sys_rd_ack <= 1'b0;
            sdram_busy <= 1'b0;
            is_write   <= 1'b0;
            addr_q     <= '0;
        end else begin
            state <= next_state;

            if (next_state != state)
                cnt_clk <= '0;
            else if (cnt_clk != CNT_MAX)
                cnt_clk <= cnt_clk + 10'd1;

            sdram_busy <= (next_state != IDLE);
            sys_wr_ack <= (next_state == WRITE) || (next_state == WD);
            sys_rd_ack <= (state == RD);

            if (state == IDLE && next_state != IDLE) begin
                addr_q   <= sys_addr;
                is_write <= sys_wr_req;
            end

            case (state)
                ACTIVE: begin
                    sdram_cmd  <= CMD_ACT;
                    sdram_ba   <= addr_q[21:20];
                    sdram_addr <= addr_q[19:8];
                end
                WRITE: begin
                    sdram_cmd  <= CMD_WRITE;
                    sdram_ba   <= addr_q[21:20];
                    sdram_addr <= {1'b0, 1'b1, 2'b00, addr_q[7:0]};
                end
                READ: begin
                    sdram_cmd  <= CMD_READ;
                    sdram_ba   <= addr_q[21:20];
                    sdram_addr <= {1'b0, 1'b1, 2'b00, addr_q[7:0]};
                end
                AR: begin
                    sdram_cmd  <= CMD_REFRESH;
                    sdram_addr <= '0;
                end
                default: sdram_cmd <= CMD_NOP;
            endcase
        end
    end

    // Refresh interval timer; a wrap coinciding with AR entry wins over the clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt     <= '0;
            ref_pending <= 1'b0;
        end else begin
            if (!init_done)
                ref_cnt <= '0;
            else if (ref_cnt == REF_LAST)
                ref_cnt <= '0;
            else
                ref_cnt <= ref_cnt + 1'b1;

            if (init_done && ref_cnt == REF_LAST)
                ref_pending <= 1'b1;
            else if (state == IDLE && next_state == AR)
                ref_pending <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sdram_burst_ctrl.sv
// tb_sdram_burst_ctrl: scenario tasks plus a command scoreboard for sdram_burst_ctrl.
module tb_sdram_burst_ctrl;

    localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RDC = 4'b0101, WRC = 4'b0100, REF = 4'b0001;
    localparam logic [3:0] S_IDLE = 4'd0, S_ACTIVE = 4'd1, S_READ = 4'd3, S_RD = 4'd5;
    localparam logic [3:0] S_WD = 4'd8, S_AR = 4'd10, S_TRFC = 4'd11;

    // Write address written as {bank, row, col} so bank=2, row=A53, col=3C
    localparam logic [21:0] WA  = {2'd2, 12'hA53, 8'h3C};
    localparam logic [21:0] RA  = 22'h1001FF;
    localparam logic [21:0] WA2 = {2'd3, 12'h7E1, 8'h05};
    localparam logic [21:0] RA2 = {2'd0, 12'h010, 8'hA0};

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        init_done = 1'b0;
    logic        sys_wr_req = 1'b0;
    logic        sys_rd_req = 1'b0;
    logic [21:0] sys_addr = '0;
    logic        sys_wr_ack, sys_rd_ack, sdram_busy;
    logic [3:0]  sdram_cmd;
    logic [1:0]  sdram_ba;
    logic [11:0] sdram_addr;
    logic [3:0]  work_state;
    logic [9:0]  cnt_clk;

    int n_compared = 0;
    int n_mismatched = 0;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [1:0]  ba;
        logic [11:0] addr;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    sdram_burst_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .init_done  (init_done),
        .sys_wr_req (sys_wr_req),
        .sys_rd_req (sys_rd_req),
        .sys_addr   (sys_addr),
        .sys_wr_ack (sys_wr_ack),
        .sys_rd_ack (sys_rd_ack),
        .sdram_busy (sdram_busy),
        .sdram_cmd  (sdram_cmd),
        .sdram_ba   (sdram_ba),
        .sdram_addr (sdram_addr),
        .work_state (work_state),
        .cnt_clk    (cnt_clk)
    );

    always #5 clk = ~clk;

    // Scoreboard: every non-NOP command must match the oldest expected command
    always @(negedge clk) begin
        if (rst_n && sdram_cmd !== NOP) begin
            n_compared++;
            if (exp_q.size() == 0) begin
                n_mismatched++;
                $display("[TB] FAIL cmd_unexpected: got cmd=%b ba=%0d addr=%h, required no command", sdram_cmd, sdram_ba, sdram_addr);
            end else begin
                mon_e = exp_q.pop_front();
                if ({sdram_cmd, sdram_ba, sdram_addr} !== mon_e) begin
                    n_mismatched++;
                    $display("[TB] FAIL cmd_seq: got cmd=%b ba=%0d addr=%h, required cmd=%b ba=%0d addr=%h", sdram_cmd, sdram_ba, sdram_addr, mon_e.cmd, mon_e.ba, mon_e.addr);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [3:0] c, input logic [1:0] b, input logic [11:0] a);
        exp_t e;
        e.cmd = c;
        e.ba = b;
        e.addr = a;
        exp_q.push_back(e);
    endtask

    task automatic do_reset(input logic init);
        rst_n = 1'b0;
        init_done = init;
        sys_wr_req = 1'b0;
        sys_rd_req = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int bad;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_compared++; if (work_state !== S_IDLE) begin n_mismatched++; $display("[TB] FAIL reset_state: got %0d required %0d", work_state, S_IDLE); end
        n_compared++; if (cnt_clk !== 10'd0) begin n_mismatched++; $display("[TB] FAIL reset_cnt: got %0d required 0", cnt_clk); end
        n_compared++; if ({sdram_cmd, sdram_ba, sdram_addr} !== {NOP, 2'd0, 12'd0}) begin n_mismatched++; $display("[TB] FAIL reset_cmd: got cmd=%b ba=%0d addr=%h required 0111/0/000", sdram_cmd, sdram_ba, sdram_addr); end
        n_compared++; if ({sys_wr_ack, sys_rd_ack, sdram_busy} !== 3'b000) begin n_mismatched++; $display("[TB] FAIL reset_flags: got %b required 000", {sys_wr_ack, sys_rd_ack, sdram_busy}); end
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (work_state !== S_IDLE || sdram_cmd !== NOP) bad++;
        end
        n_compared++; if (bad !== 0) begin n_mismatched++; $display("[TB] FAIL reset_release_idle: got %0d non-idle cycles required 0", bad); end
    endtask

    task automatic test_single_write();
        int act_idx, wr_idx, ack_first, ack_last, ack_cnt, busy_cnt, wd_max;
        logic [3:0] st1;
        do_reset(1'b1);
        push_exp(ACT, 2'd2, 12'hA53);
        push_exp(WRC, 2'd2, 12'h43C);
        act_idx = -1; wr_idx = -1; ack_first = -1; ack_last = -1; ack_cnt = 0; busy_cnt = 0; wd_max = 0; st1 = 4'hF;
        sys_addr = WA;
        sys_wr_req = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (i == 1) st1 = work_state;
            if (sdram_cmd === ACT && act_idx < 0) act_idx = i;
            if (sdram_cmd === WRC && wr_idx < 0) wr_idx = i;
            if (sys_wr_ack === 1'b1) begin
                if (ack_first < 0) ack_first = i;
                ack_last = i;
                ack_cnt++;
                sys_wr_req = 1'b0;
            end
            if (sdram_busy === 1'b1) busy_cnt++;
            if (work_state === S_WD && int'(cnt_clk) > wd_max) wd_max = int'(cnt_clk);
        end
        n_compared++; if (st1 !== S_ACTIVE) begin n_mismatched++; $display("[TB] FAIL wr_active_latency: got state %0d required %0d", st1, S_ACTIVE); end
        n_compared++; if (act_idx !== 2) begin n_mismatched++; $display("[TB] FAIL wr_act_cycle: got %0d required 2", act_idx); end
        n_compared++; if (wr_idx !== 4) begin n_mismatched++; $display("[TB] FAIL wr_cmd_cycle: got %0d required 4", wr_idx); end
        n_compared++; if (ack_first !== 3 || ack_cnt !== 8 || ack_last - ack_first + 1 !== 8) begin n_mismatched++; $display("[TB] FAIL wr_ack_window: got first=%0d count=%0d last=%0d required 3/8/10", ack_first, ack_cnt, ack_last); end
        n_compared++; if (busy_cnt !== 14) begin n_mismatched++; $display("[TB] FAIL wr_busy_len: got %0d required 14", busy_cnt); end
        n_compared++; if (wd_max !== 6) begin n_mismatched++; $display("[TB] FAIL wr_wd_cnt_clk: got %0d required 6", wd_max); end
        n_compared++; if (work_state !== S_IDLE) begin n_mismatched++; $display("[TB] FAIL wr_end_idle: got %0d required 0", work_state); end
    endtask

    task automatic test_reset_mid_burst();
        int found, bad;
        do_reset(1'b1);
        push_exp(ACT, 2'd2, 12'hA53);
        push_exp(WRC, 2'd2, 12'h43C);
        sys_addr = WA;
        sys_wr_req = 1'b1;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            tick();
            if (sys_wr_ack === 1'b1) sys_wr_req = 1'b0;
            if (work_state === S_WD && cnt_clk === 10'd3) found = 1;
        end
        n_compared++; if (found !== 1) begin n_mismatched++; $display("[TB] FAIL midrst_reach_wd: got found=%0d required 1", found); end
        #2 rst_n = 1'b0;
        sys_wr_req = 1'b0;
        #1;
        n_compared++; if (work_state !== S_IDLE || cnt_clk !== 10'd0) begin n_mismatched++; $display("[TB] FAIL midrst_state: got state=%0d cnt=%0d required 0/0", work_state, cnt_clk); end
        n_compared++; if ({sdram_cmd, sdram_ba, sdram_addr} !== {NOP, 2'd0, 12'd0}) begin n_mismatched++; $display("[TB] FAIL midrst_cmd: got cmd=%b ba=%0d addr=%h required 0111/0/000", sdram_cmd, sdram_ba, sdram_addr); end
        n_compared++; if ({sys_wr_ack, sys_rd_ack, sdram_busy} !== 3'b000) begin n_mismatched++; $display("[TB] FAIL midrst_flags: got %b required 000", {sys_wr_ack, sys_rd_ack, sdram_busy}); end
        tick();
        tick();
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (work_state !== S_IDLE || sdram_cmd !== NOP || sdram_busy !== 1'b0) bad++;
        end
        n_compared++; if (bad !== 0) begin n_mismatched++; $display("[TB] FAIL midrst_after: got %0d active cycles required 0", bad); end
    endtask

    task automatic test_single_read();
        int act_idx, rd_idx, read_first, rdst_first, ack_first, ack_last, ack_cnt, busy_cnt;
        do_reset(1'b1);
        push_exp(ACT, 2'd1, 12'h001);
        push_exp(RDC, 2'd1, 12'h4FF);
        act_idx = -1; rd_idx = -1; read_first = -1; rdst_first = -1; ack_first = -1; ack_last = -1; ack_cnt = 0; busy_cnt = 0;
        sys_addr = RA;
        sys_rd_req = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (sdram_cmd === ACT && act_idx < 0) act_idx = i;
            if (sdram_cmd === RDC && rd_idx < 0) rd_idx = i;
            if (work_state === S_READ && read_first < 0) read_first = i;
            if (work_state === S_RD && rdst_first < 0) rdst_first = i;
            if (sys_rd_ack === 1'b1) begin
                if (ack_first < 0) ack_first = i;
                ack_last = i;
                ack_cnt++;
                sys_rd_req = 1'b0;
            end
            if (sdram_busy === 1'b1) busy_cnt++;
        end
        n_compared++; if (act_idx !== 2 || rd_idx !== 4) begin n_mismatched++; $display("[TB] FAIL rd_cmd_cycles: got act=%0d read=%0d required 2/4", act_idx, rd_idx); end
        n_compared++; if (read_first !== 3 || rdst_first !== read_first + 3) begin n_mismatched++; $display("[TB] FAIL rd_cl_latency: got READ=%0d RD=%0d required 3/6", read_first, rdst_first); end
        n_compared++; if (ack_first !== rdst_first + 1 || ack_cnt !== 8 || ack_last - ack_first + 1 !== 8) begin n_mismatched++; $display("[TB] FAIL rd_ack_window: got first=%0d count=%0d last=%0d required 7/8/14", ack_first, ack_cnt, ack_last); end
        n_compared++; if (busy_cnt !== 15) begin n_mismatched++; $display("[TB] FAIL rd_busy_len: got %0d required 15", busy_cnt); end
    endtask

    task automatic test_arbitration();
        int wr_first, rack_first, idle_idx, act2_idx, busy_cnt;
        do_reset(1'b1);
        push_exp(ACT, 2'd3, 12'h7E1);
        push_exp(WRC, 2'd3, 12'h405);
        push_exp(ACT, 2'd0, 12'h010);
        push_exp(RDC, 2'd0, 12'h4A0);
        wr_first = -1; rack_first = -1; idle_idx = -1; act2_idx = -1; busy_cnt = 0;
        sys_addr = WA2;
        sys_wr_req = 1'b1;
        sys_rd_req = 1'b1;
        for (int i = 1; i <= 45; i++) begin
            tick();
            if (sys_wr_ack === 1'b1) begin
                if (wr_first < 0) wr_first = i;
                sys_wr_req = 1'b0;
                sys_addr = RA2;
            end
            if (sys_rd_ack === 1'b1) begin
                if (rack_first < 0) rack_first = i;
                sys_rd_req = 1'b0;
            end
            if (i > 1 && idle_idx < 0 && work_state === S_IDLE) idle_idx = i;
            if (idle_idx > 0 && act2_idx < 0 && work_state === S_ACTIVE) act2_idx = i;
            if (sdram_busy === 1'b1) busy_cnt++;
        end
        n_compared++; if (wr_first !== 3) begin n_mismatched++; $display("[TB] FAIL arb_write_first: got wr_ack at %0d required 3", wr_first); end
        n_compared++; if (idle_idx !== 15 || act2_idx !== 16) begin n_mismatched++; $display("[TB] FAIL arb_gap: got idle=%0d active=%0d required 15/16", idle_idx, act2_idx); end
        n_compared++; if (rack_first !== 22) begin n_mismatched++; $display("[TB] FAIL arb_read_ack: got %0d required 22", rack_first); end
        n_compared++; if (busy_cnt !== 29) begin n_mismatched++; $display("[TB] FAIL arb_busy_total: got %0d required 29", busy_cnt); end
    endtask

    task automatic test_refresh();
        int ref1, ref2, trfc_busy, st1_ok, refc_idx, trfc_cnt, act_idx, wr_first, rack_first;
        do_reset(1'b1);
        push_exp(REF, 2'd0, 12'd0);
        push_exp(REF, 2'd0, 12'd0);
        ref1 = -1; ref2 = -1; trfc_busy = 0;
        for (int i = 1; i <= 1700 && ref2 < 0; i++) begin
            tick();
            if (sdram_cmd === REF) begin
                if (ref1 < 0) ref1 = i;
                else ref2 = i;
            end
            if (ref1 > 0 && ref2 < 0 && i <= ref1 + 20 && work_state === S_TRFC) trfc_busy++;
        end
        n_compared++; if (ref1 !== 782) begin n_mismatched++; $display("[TB] FAIL ref_first: got cycle %0d required 782", ref1); end
        n_compared++; if (ref2 < 0 || ref2 - ref1 !== 780) begin n_mismatched++; $display("[TB] FAIL ref_interval: got %0d required 780", ref2 - ref1); end
        n_compared++; if (trfc_busy !== 6) begin n_mismatched++; $display("[TB] FAIL ref_idle_trfc: got %0d required 6", trfc_busy); end
        push_exp(REF, 2'd0, 12'd0);
        push_exp(ACT, 2'd2, 12'hA53);
        push_exp(WRC, 2'd2, 12'h43C);
        push_exp(ACT, 2'd1, 12'h001);
        push_exp(RDC, 2'd1, 12'h4FF);
        repeat (778) tick();
        sys_addr = WA;
        sys_wr_req = 1'b1;
        sys_rd_req = 1'b1;
        st1_ok = 0; refc_idx = -1; trfc_cnt = 0; act_idx = -1; wr_first = -1; rack_first = -1;
        for (int i = 1; i <= 50; i++) begin
            tick();
            if (i == 1 && work_state === S_AR) st1_ok = 1;
            if (sdram_cmd === REF && refc_idx < 0) refc_idx = i;
            if (work_state === S_TRFC) trfc_cnt++;
            if (work_state === S_ACTIVE && act_idx < 0) act_idx = i;
            if (sys_wr_ack === 1'b1) begin
                if (wr_first < 0) wr_first = i;
                sys_wr_req = 1'b0;
                sys_addr = RA;
            end
            if (sys_rd_ack === 1'b1) begin
                if (rack_first < 0) rack_first = i;
                sys_rd_req = 1'b0;
            end
        end
        n_compared++; if (st1_ok !== 1 || refc_idx !== 2) begin n_mismatched++; $display("[TB] FAIL ref_priority: got AR_first=%0d refresh_cycle=%0d required 1/2", st1_ok, refc_idx); end
        n_compared++; if (trfc_cnt !== 6) begin n_mismatched++; $display("[TB] FAIL ref_trfc_len: got %0d required 6", trfc_cnt); end
        n_compared++; if (act_idx !== 9 || wr_first !== 11 || rack_first !== 30) begin n_mismatched++; $display("[TB] FAIL ref_then_bursts: got active=%0d wr_ack=%0d rd_ack=%0d required 9/11/30", act_idx, wr_first, rack_first); end
    endtask

    task automatic test_init_gating();
        int bad_cmd, bad_busy, act_idx, wr_cnt, busy_cnt;
        do_reset(1'b0);
        sys_addr = WA;
        sys_wr_req = 1'b1;
        sys_rd_req = 1'b1;
        bad_cmd = 0; bad_busy = 0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (sdram_cmd !== NOP || work_state !== S_IDLE) bad_cmd++;
            if (sdram_busy !== 1'b0) bad_busy++;
        end
        n_compared++; if (bad_cmd !== 0) begin n_mismatched++; $display("[TB] FAIL gate_cmd: got %0d active cycles required 0", bad_cmd); end
        n_compared++; if (bad_busy !== 0) begin n_mismatched++; $display("[TB] FAIL gate_busy: got %0d busy cycles required 0", bad_busy); end
        n_compared++; if (cnt_clk !== 10'd1023) begin n_mismatched++; $display("[TB] FAIL gate_cnt_sat: got %0d required 1023", cnt_clk); end
        push_exp(ACT, 2'd2, 12'hA53);
        push_exp(WRC, 2'd2, 12'h43C);
        push_exp(ACT, 2'd1, 12'h001);
        push_exp(RDC, 2'd1, 12'h4FF);
        init_done = 1'b1;
        act_idx = -1;
        for (int i = 1; i <= 45; i++) begin
            tick();
            if (work_state === S_ACTIVE && act_idx < 0) act_idx = i;
            if (sys_wr_ack === 1'b1) begin sys_wr_req = 1'b0; sys_addr = RA; end
            if (sys_rd_ack === 1'b1) sys_rd_req = 1'b0;
        end
        n_compared++; if (act_idx !== 1) begin n_mismatched++; $display("[TB] FAIL gate_release: got active at %0d required 1", act_idx); end
        push_exp(ACT, 2'd2, 12'hA53);
        push_exp(WRC, 2'd2, 12'h43C);
        sys_addr = WA;
        sys_wr_req = 1'b1;
        sys_rd_req = 1'b1;
        wr_cnt = 0; busy_cnt = 0;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (sys_wr_ack === 1'b1) begin wr_cnt++; sys_wr_req = 1'b0; end
            if (work_state === S_WD && cnt_clk === 10'd0) init_done = 1'b0;
            if (sdram_busy === 1'b1) busy_cnt++;
        end
        n_compared++; if (wr_cnt !== 8 || busy_cnt !== 14 || work_state !== S_IDLE) begin n_mismatched++; $display("[TB] FAIL gate_midop: got wr_ack=%0d busy=%0d state=%0d required 8/14/0", wr_cnt, busy_cnt, work_state); end
        sys_rd_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_reset_mid_burst();
        test_single_read();
        test_arbitration();
        test_refresh();
        test_init_gating();
        tick();
        n_compared++; if (exp_q.size() !== 0) begin n_mismatched++; $display("[TB] FAIL cmd_missing: got %0d commands never issued required 0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
